// File: rtl/aircon_pkg.sv
// Shared types and default constants for the aircon_ctrl thermostat.
// The optional fan run-on logic in the top level is built only when
// the macro AIRCON_FAN_EN is defined.
package aircon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAT = 2'b01,
        ST_COOL = 2'b10
    } state_t;

    localparam int DEF_TEMP_W    = 5;
    localparam int DEF_HEAT_ON   = 18;
    localparam int DEF_HEAT_OFF  = 20;
    localparam int DEF_COOL_OFF  = 20;
    localparam int DEF_COOL_ON   = 22;
    localparam int DEF_MIN_DWELL = 4;
    localparam int DEF_FAN_TAIL  = 3;

    // Counter width able to hold 0..n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/aircon_ctrl_dwell_timer.sv
// Down-counter that reloads to LOAD, counts to zero and reports done.
// Used both as the anti-short-cycle dwell timer and as the fan tail timer.
module dwell_timer
    import aircon_pkg::*;
#(
    parameter int LOAD = DEF_MIN_DWELL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clr,
    output logic done
);

    localparam int            CW     = cnt_width(LOAD);
    localparam logic [CW-1:0] LOAD_V = CW'(LOAD);
    localparam logic [CW-1:0] ZERO_V = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_V  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over load, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = ZERO_V;
        end else if (load) begin
            cnt_d = LOAD_V;
        end else if (cnt_q != ZERO_V) begin
            cnt_d = cnt_q - ONE_V;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= ZERO_V;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == ZERO_V);

endmodule

// File: rtl/aircon_ctrl.sv
// Hysteresis thermostat with minimum-dwell anti-short-cycle protection.
// Heating and cooling are decoded from a registered IDLE/HEAT/COOL state.
// Define AIRCON_FAN_EN to add the fan output with a FAN_TAIL run-on.
module aircon_ctrl
    import aircon_pkg::*;
#(
    parameter int TEMP_W    = DEF_TEMP_W,
    parameter int HEAT_ON   = DEF_HEAT_ON,
    parameter int HEAT_OFF  = DEF_HEAT_OFF,
    parameter int COOL_OFF  = DEF_COOL_OFF,
    parameter int COOL_ON   = DEF_COOL_ON,
    parameter int MIN_DWELL = DEF_MIN_DWELL,
    parameter int FAN_TAIL  = DEF_FAN_TAIL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [TEMP_W-1:0] temperature,
    output logic              heating,
    output logic              cooling,
    output logic [1:0]        state
`ifdef AIRCON_FAN_EN
    ,
    output logic              fan
`endif
);

    // Threshold ordering must hold or the hysteresis bands overlap.
    if (!(HEAT_ON < HEAT_OFF && HEAT_OFF <= COOL_OFF && COOL_OFF < COOL_ON &&
          COOL_ON < (2 ** TEMP_W) && HEAT_ON >= 0 && MIN_DWELL >= 0 &&
          FAN_TAIL >= 0)) begin : g_bad_params
        $fatal(1, "aircon_ctrl: illegal threshold/timer parameters");
    end

    localparam logic [TEMP_W-1:0] HEAT_ON_T  = TEMP_W'(HEAT_ON);
    localparam logic [TEMP_W-1:0] HEAT_OFF_T = TEMP_W'(HEAT_OFF);
    localparam logic [TEMP_W-1:0] COOL_OFF_T = TEMP_W'(COOL_OFF);
    localparam logic [TEMP_W-1:0] COOL_ON_T  = TEMP_W'(COOL_ON);

    state_t state_q;
    state_t state_d;
    logic   heating_q;
    logic   cooling_q;
    logic   dwell_done_s;
    logic   state_chg_s;

    // Next state: disable forces IDLE; otherwise moves only once dwell expired.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (dwell_done_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (temperature <= HEAT_ON_T) begin
                        state_d = ST_HEAT;
                    end else if (temperature >= COOL_ON_T) begin
                        state_d = ST_COOL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HEAT: begin
                    if (temperature >= HEAT_OFF_T) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HEAT;
                    end
                end
                ST_COOL: begin
                    if (temperature <= COOL_OFF_T) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_COOL;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign state_chg_s = (state_d != state_q);

    // State register with registered heater/cooler drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            heating_q <= 1'b0;
            cooling_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            heating_q <= (state_d == ST_HEAT);
            cooling_q <= (state_d == ST_COOL);
        end
    end

    // Dwell restarts on every state change; disable clears it outright.
    dwell_timer #(
        .LOAD (MIN_DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state_chg_s),
        .clr   (!enable),
        .done  (dwell_done_s)
    );

    assign heating = heating_q;
    assign cooling = cooling_q;
    assign state   = state_q;

`ifdef AIRCON_FAN_EN
    logic tail_done_s;
    logic tail_load_s;
    logic tail_clr_s;

    // Tail starts when leaving an active state and is cancelled on re-entry.
    assign tail_load_s = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    assign tail_clr_s  = (state_d != ST_IDLE);

    dwell_timer #(
        .LOAD (FAN_TAIL)
    ) u_fan_tail (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tail_load_s),
        .clr   (tail_clr_s),
        .done  (tail_done_s)
    );

    assign fan = heating_q || cooling_q || !tail_done_s;
`endif

endmodule
